// File: rtl/calc_btn_ctrl.sv
// calc_btn_ctrl: button front end for the calculator datapath.
// Synchronises and debounces the five board buttons, encodes the l/c/r chord
// into an ALU op code, and hands the op to the accumulator through a
// valid/ready holding register. btnu issues a clear; btnd executes, with
// optional auto-repeat while it is held.

`default_nettype none

module calc_btn_ctrl #(
    parameter int SYNC_STAGES   = 2,       // synchroniser depth, >= 2
    parameter int DB_CYCLES     = 500000,  // disagreement cycles before flip, >= 1
    parameter int REPEAT_CYCLES = 0        // auto-repeat period, 0 disables
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnc,
    input  logic       btnl,
    input  logic       btnr,
    input  logic       btnu,
    input  logic       btnd,
    input  logic       op_ready,
    output logic [3:0] encout,
    output logic       op_valid,
    output logic       clr_pulse,
    output logic       overrun,
    output logic [4:0] btn_db
);

    localparam int NBTN  = 5;
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam int RPT_W = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES);

    // Button bit positions inside btn_db: {d,u,r,l,c}
    localparam int B_C = 0;
    localparam int B_L = 1;
    localparam int B_R = 2;
    localparam int B_U = 3;
    localparam int B_D = 4;

    // Output holding register: empty, or holding an op not yet accepted
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    logic [NBTN-1:0]        w_raw;
    logic [NBTN-1:0]        w_sync;
    logic [NBTN-1:0]        w_rise;
    logic [SYNC_STAGES-1:0] r_sync [NBTN];
    logic [CNT_W-1:0]       r_cnt  [NBTN];
    logic [NBTN-1:0]        r_db;
    logic [NBTN-1:0]        r_db_d;
    logic [RPT_W-1:0]       r_rpt_cnt;
    logic                   w_tick;
    logic                   w_exec;
    logic                   w_clear;
    logic [3:0]             w_enc;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_encout;
    logic [3:0]             w_encout_nxt;
    logic                   r_overrun;
    logic                   w_overrun_nxt;
    logic                   r_clr_pulse;
    logic                   w_clr_pulse_nxt;

    // Chord {l,c,r} to ALU operation code
    function automatic logic [3:0] encode_op(input logic [2:0] lcr);
        logic [3:0] op;
        case (lcr)
            3'b000:  op = 4'b0000;
            3'b001:  op = 4'b0001;
            3'b010:  op = 4'b0010;
            3'b011:  op = 4'b0110;
            3'b100:  op = 4'b0100;
            3'b101:  op = 4'b1001;
            3'b110:  op = 4'b1010;
            3'b111:  op = 4'b0101;
            default: op = 4'b0000;
        endcase
        return op;
    endfunction

    assign w_raw = {btnd, btnu, btnr, btnl, btnc};

    // Shift each raw button through its synchroniser chain
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge value of its neighbours, exactly like the hardware.
        if (rst) begin
            // NOTE: these arrays are plain flops rather than a RAM, so they
            // take the reset like any other register and the post-reset
            // state is fully defined.
            for (int i = 0; i < NBTN; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
            end
        end
    end

    // Pick the last synchroniser stage of every button
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        w_sync = '0;
        for (int i = 0; i < NBTN; i++) begin
            w_sync[i] = r_sync[i][SYNC_STAGES-1];
        end
    end

    // Debounce: flip only after DB_CYCLES consecutive cycles of disagreement
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db <= '0;
            for (int i = 0; i < NBTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (w_sync[i] != r_db[i]) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_db[i]  <= w_sync[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Delayed debounced levels for rise detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_d <= '0;
        end else begin
            r_db_d <= r_db;
        end
    end

    assign w_rise = r_db & ~r_db_d;

    // Repeat counter: counts from the btnd rise, wraps to 1 on each tick
    // so ticks land at REPEAT_CYCLES * k after the rise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rpt_cnt <= '0;
        end else if (REPEAT_CYCLES == 0 || !r_db[B_D]) begin
            r_rpt_cnt <= '0;
        end else if (w_tick) begin
            r_rpt_cnt <= RPT_W'(1);
        end else begin
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
        end
    end

    assign w_tick  = (REPEAT_CYCLES > 0) && r_db[B_D] && (r_rpt_cnt == RPT_LAST);
    assign w_exec  = w_rise[B_D] | w_tick;
    assign w_clear = w_rise[B_U];
    assign w_enc   = encode_op({r_db[B_L], r_db[B_C], r_db[B_R]});

    // Holding register state and its payload
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_encout    <= '0;
            r_overrun   <= 1'b0;
            r_clr_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_encout    <= w_encout_nxt;
            r_overrun   <= w_overrun_nxt;
            r_clr_pulse <= w_clr_pulse_nxt;
        end
    end

    // Next state: clear beats execute; a full register only reloads when the
    // consumer accepts in the same cycle, otherwise the event is an overrun
    always_comb begin
        w_state_nxt     = r_state;
        w_encout_nxt    = r_encout;
        w_overrun_nxt   = r_overrun;
        w_clr_pulse_nxt = w_clear;

        if (w_clear) begin
            w_state_nxt   = S_EMPTY;
            w_overrun_nxt = 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_exec) begin
                        w_encout_nxt = w_enc;
                        w_state_nxt  = S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_exec) begin
                        if (op_ready) begin
                            w_encout_nxt = w_enc;
                        end else begin
                            w_overrun_nxt = 1'b1;
                        end
                    end else if (op_ready) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    assign encout    = r_encout;
    assign op_valid  = (r_state == S_FULL);
    assign clr_pulse = r_clr_pulse;
    assign overrun   = r_overrun;
    assign btn_db    = r_db;

endmodule

`default_nettype wire

// File: tb/tb_calc_btn_ctrl.sv
// tb_calc_btn_ctrl: directed vectors for calc_btn_ctrl with short debounce.
// Instance u_dut has repeat disabled, u_rpt repeats every 10 cycles; both
// share the buttons and reset, each has its own op_ready.

`timescale 1ns/1ps

module tb_calc_btn_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnc = 1'b0, btnl = 1'b0, btnr = 1'b0, btnu = 1'b0, btnd = 1'b0;
    logic       rdy_a = 1'b0, rdy_b = 1'b0;

    logic [3:0] a_encout, b_encout;
    logic       a_op_valid, b_op_valid;
    logic       a_clr_pulse, b_clr_pulse;
    logic       a_overrun, b_overrun;
    logic [4:0] a_btn_db, b_btn_db;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    calc_btn_ctrl #(.SYNC_STAGES(2), .DB_CYCLES(4), .REPEAT_CYCLES(0)) u_dut (
        .clk(clk), .rst(rst),
        .btnc(btnc), .btnl(btnl), .btnr(btnr), .btnu(btnu), .btnd(btnd),
        .op_ready(rdy_a),
        .encout(a_encout), .op_valid(a_op_valid), .clr_pulse(a_clr_pulse),
        .overrun(a_overrun), .btn_db(a_btn_db)
    );

    calc_btn_ctrl #(.SYNC_STAGES(2), .DB_CYCLES(4), .REPEAT_CYCLES(10)) u_rpt (
        .clk(clk), .rst(rst),
        .btnc(btnc), .btnl(btnl), .btnr(btnr), .btnu(btnu), .btnd(btnd),
        .op_ready(rdy_b),
        .encout(b_encout), .op_valid(b_op_valid), .clr_pulse(b_clr_pulse),
        .overrun(b_overrun), .btn_db(b_btn_db)
    );

    // Advance n cycles; inputs change and outputs are sampled on negedges
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [3:0]  enc_tab [8];
    logic [63:0] mask_a, mask_b, exp_mask_a, exp_mask_b;
    logic        seen_rise;

    initial begin
        enc_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                    4'b0100, 4'b1001, 4'b1010, 4'b0101};

        // Reset state
        cyc(3);
        check("rst_encout",   a_encout,    4'b0000);
        check("rst_op_valid", a_op_valid,  1'b0);
        check("rst_clr",      a_clr_pulse, 1'b0);
        check("rst_overrun",  a_overrun,   1'b0);
        check("rst_btn_db",   a_btn_db,    5'b00000);
        rst = 1'b0;

        // Chord l+r, then btnd: op_valid exactly 7 cycles after raw rise
        btnl = 1'b1; btnr = 1'b1;
        cyc(8);
        check("lr_btn_db", a_btn_db, 5'b00110);
        btnd = 1'b1;
        cyc(6);
        check("lat_not_yet", a_op_valid, 1'b0);
        cyc(1);
        check("lat_valid",   a_op_valid, 1'b1);
        check("lat_encout",  a_encout,   4'b1001);
        check("lat_valid_b", b_op_valid, 1'b1);
        btnd = 1'b0;
        rdy_a = 1'b1; rdy_b = 1'b1;
        cyc(1);
        check("accept_drop",  a_op_valid, 1'b0);
        check("accept_keep",  a_encout,   4'b1001);
        rdy_a = 1'b0; rdy_b = 1'b0;
        btnl = 1'b0; btnr = 1'b0;
        cyc(8);

        // Bounce: 3-cycle pulses never reach the debounced level
        seen_rise = 1'b0;
        for (int i = 0; i < 20; i++) begin
            btnd = ((i / 3) % 2) == 0;
            cyc(1);
            if (a_btn_db[4] || b_btn_db[4]) seen_rise = 1'b1;
        end
        btnd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (a_btn_db[4] || b_btn_db[4]) seen_rise = 1'b1;
        end
        check("bounce_db",    seen_rise,  1'b0);
        check("bounce_valid", a_op_valid, 1'b0);
        check("bounce_valid_b", b_op_valid, 1'b0);

        // All eight chords with op_ready held high
        rdy_a = 1'b1; rdy_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {btnl, btnc, btnr} = 3'(i);
            cyc(8);
            btnd = 1'b1;
            cyc(7);
            check($sformatf("chord%0d_enc", i), a_encout, enc_tab[i]);
            check($sformatf("chord%0d_vld", i), a_op_valid, 1'b1);
            btnd = 1'b0;
            cyc(8);
        end
        btnl = 1'b0; btnc = 1'b0; btnr = 1'b0;
        rdy_a = 1'b0; rdy_b = 1'b0;
        cyc(8);

        // Overrun: second press with op_ready low is dropped
        btnc = 1'b1;
        cyc(8);
        btnd = 1'b1;
        cyc(7);
        check("ovr_first_vld", a_op_valid, 1'b1);
        check("ovr_first_enc", a_encout,   4'b0010);
        check("ovr_first_ovr", a_overrun,  1'b0);
        btnd = 1'b0;
        cyc(8);
        btnc = 1'b0; btnl = 1'b1;
        cyc(8);
        btnd = 1'b1;
        cyc(7);
        check("ovr_second_enc", a_encout,   4'b0010);
        check("ovr_second_ovr", a_overrun,  1'b1);
        check("ovr_second_vld", a_op_valid, 1'b1);
        check("ovr_second_ovr_b", b_overrun, 1'b1);
        btnd = 1'b0;
        cyc(8);

        // Clear: one-cycle pulse, drops op_valid and overrun, keeps encout
        btnu = 1'b1;
        cyc(6);
        check("clr_not_yet", a_clr_pulse, 1'b0);
        cyc(1);
        check("clr_pulse",   a_clr_pulse, 1'b1);
        check("clr_vld",     a_op_valid,  1'b0);
        check("clr_ovr",     a_overrun,   1'b0);
        check("clr_enc",     a_encout,    4'b0010);
        cyc(1);
        check("clr_one_cyc", a_clr_pulse, 1'b0);
        btnu = 1'b0;
        cyc(8);

        // Load again, then clear and execute together: clear wins, no overrun
        btnd = 1'b1;
        cyc(7);
        check("reload_vld", a_op_valid, 1'b1);
        check("reload_enc", a_encout,   4'b0100);
        btnd = 1'b0;
        cyc(8);
        btnd = 1'b1; btnu = 1'b1;
        cyc(7);
        check("clrx_pulse", a_clr_pulse, 1'b1);
        check("clrx_vld",   a_op_valid,  1'b0);
        check("clrx_ovr",   a_overrun,   1'b0);
        check("clrx_enc",   a_encout,    4'b0100);
        btnd = 1'b0; btnu = 1'b0;
        btnl = 1'b0; btnc = 1'b1;
        cyc(10);

        // Auto-repeat: rise at edge 7, ticks land 10/20/30 cycles later
        rdy_a = 1'b1; rdy_b = 1'b1;
        mask_a = '0; mask_b = '0;
        btnd = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            if (e == 36) btnd = 1'b0;
            cyc(1);
            if (a_op_valid) mask_a[e] = 1'b1;
            if (b_op_valid) mask_b[e] = 1'b1;
        end
        exp_mask_a = 64'd1 << 7;
        exp_mask_b = (64'd1 << 7) | (64'd1 << 17) | (64'd1 << 27) | (64'd1 << 37);
        check("rpt_off_events", mask_a, exp_mask_a);
        check("rpt_on_events",  mask_b, exp_mask_b);
        check("rpt_enc",        b_encout, 4'b0010);
        cyc(4);

        // Back-to-back: tick coincides with acceptance, new chord loads
        rdy_b = 1'b0;
        btnd = 1'b1;
        cyc(7);
        check("b2b_first_vld", b_op_valid, 1'b1);
        check("b2b_first_enc", b_encout,   4'b0010);
        btnc = 1'b0; btnr = 1'b1;
        cyc(9);
        rdy_b = 1'b1;
        cyc(1);
        check("b2b_vld", b_op_valid, 1'b1);
        check("b2b_enc", b_encout,   4'b0001);
        check("b2b_ovr", b_overrun,  1'b0);
        rdy_b = 1'b0;
        btnd = 1'b0;
        cyc(1);
        check("b2b_hold", b_op_valid, 1'b1);
        rdy_b = 1'b1;
        cyc(1);
        check("b2b_drain", b_op_valid, 1'b0);
        rdy_b = 1'b0;
        cyc(8);
        btnr = 1'b0;
        cyc(8);

        // Reset mid-handshake with buttons held
        rdy_a = 1'b0;
        btnl = 1'b1;
        cyc(8);
        btnd = 1'b1;
        cyc(7);
        btnd = 1'b0;
        cyc(8);
        btnd = 1'b1;
        cyc(7);
        check("pre_rst_vld", a_op_valid, 1'b1);
        check("pre_rst_ovr", a_overrun,  1'b1);
        rst = 1'b1;
        cyc(1);
        check("mid_rst_enc",   a_encout,    4'b0000);
        check("mid_rst_vld",   a_op_valid,  1'b0);
        check("mid_rst_ovr",   a_overrun,   1'b0);
        check("mid_rst_clr",   a_clr_pulse, 1'b0);
        check("mid_rst_db",    a_btn_db,    5'b00000);
        check("mid_rst_enc_b", b_encout,    4'b0000);
        rst = 1'b0;
        cyc(6);
        check("post_rst_not_yet", a_op_valid, 1'b0);
        cyc(1);
        check("post_rst_vld", a_op_valid, 1'b1);
        check("post_rst_enc", a_encout,   4'b0100);
        btnd = 1'b0; btnl = 1'b0;
        cyc(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/calc_btn_ctrl.md
# calc_btn_ctrl

Parametrised button front end for the calculator datapath: synchronises and debounces the five board buttons, encodes the left/centre/right chord into a 4-bit ALU operation, and presents it through a valid/ready handshake on each execute press. Adds an optional auto-repeat mode and a clear command. It sits between the board push-buttons and the calculator accumulator/ALU control.

## Interface
- SYNC_STAGES, 2, synchroniser flops per button input (≥2)
- DB_CYCLES, 500000, consecutive cycles of disagreement needed before the debounced state flips (≥1); counter width = clog2(DB_CYCLES+1)
- REPEAT_CYCLES, 0, auto-repeat period in cycles while btnd is held; 0 disables repeat
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- btnc, btnl, btnr  in  1 each  raw operation-select buttons (asynchronous)
- btnu  in  1  raw clear button (asynchronous)
- btnd  in  1  raw execute button (asynchronous)
- op_ready  in  1  consumer accepts encout when high with op_valid
- encout  out  4  latched ALU operation code
- op_valid  out  1  encout holds an unaccepted operation
- clr_pulse  out  1  one-cycle pulse on debounced btnu rise
- overrun  out  1  sticky: an execute event was dropped
- btn_db  out  5  debounced levels {d,u,r,l,c} (bit0 = c)

## Operation
- Per button: SYNC_STAGES-flop synchroniser → debouncer. Debouncer: if sync ≠ db, cnt increments; when sync ≠ db and cnt == DB_CYCLES−1, db <= sync, cnt <= 0. Any cycle with sync == db clears cnt.
- Rise detect: registered copy db_d; rise = db & ~db_d.
- Encoding of debounced {l,c,r} (l,c,r → encout): 000→0000, 001→0001, 010→0010, 011→0110, 100→0100, 101→1001, 110→1010, 111→0101.
- Execute event = rise of btn_db[4], or repeat tick. Repeat: when REPEAT_CYCLES>0 and btn_db[4] high, rpt_cnt counts from the rise; every REPEAT_CYCLES cycles after the rise a tick fires; rpt_cnt clears when btn_db[4] is low.
- Op capture: on an execute event, encout <= encode(current btn_db[2:0]), op_valid <= 1.
- Handshake: encout stable while op_valid high. op_valid & op_ready in a cycle → op_valid falls next edge, unless a new event occurs in that same cycle (then the new op loads, op_valid stays 1: back-to-back).
- Event while op_valid=1 and op_ready=0: event dropped, encout unchanged, overrun <= 1.
- Clear: rise of btn_db[3] → clr_pulse high one cycle; same edge clears op_valid and overrun. Clear and execute in the same cycle: clear wins, execute dropped without setting overrun.
- encout is not cleared by clear; only by rst.

## Timing
- Reset: encout=0, op_valid=0, clr_pulse=0, overrun=0, btn_db=0, all sync flops, db_d, cnt, rpt_cnt = 0. rst overrides everything, including mid-debounce or mid-handshake.
- Raw change → synchroniser output: SYNC_STAGES cycles. Sync → btn_db: DB_CYCLES cycles (stable input). Raw btnd rise → op_valid high: SYNC_STAGES+DB_CYCLES+1 cycles. Same for clr_pulse from btnu.
- Glitch shorter than DB_CYCLES cycles at sync output: no change to btn_db.
- Button held through reset release: seen as a rise after full latency (db starts at 0).
- Repeat tick k (k≥1) fires REPEAT_CYCLES·k cycles after the initial rise; op_valid updates one cycle later.
- Encoding uses btn_db[2:0] sampled in the event cycle; l/c/r changes after capture do not affect encout.

## Test plan
- SYNC_STAGES=2, DB_CYCLES=4: hold btnl=1,btnr=1, press btnd → op_valid rises exactly 7 cycles after raw btnd rise, encout=1001; op_ready=1 one cycle → op_valid 0 next edge.
- Bounce: btnd toggles with 3-cycle pulses for 20 cycles then stays low → btn_db[4] never rises, op_valid stays 0.
- All eight l/c/r chords each followed by btnd press with op_ready=1 → encout sequence 0000,0001,0010,0110,0100,1001,1010,0101.
- op_ready=0, two btnd presses → first op retained, overrun=1 after second; btnu press → clr_pulse one cycle, op_valid=0, overrun=0, encout unchanged.
- REPEAT_CYCLES=10, btnc held, btnd held 35 cycles past debounce, op_ready=1 → four events (rise + ticks at 10,20,30), encout=0010 each; back-to-back acceptance keeps op_valid high where events coincide with acceptance.
- Assert rst mid-handshake (op_valid=1, overrun=1) → next edge all outputs 0; buttons still held → fresh events after full latency.
